quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Quadrature encoder front end for the up/down counter stage. It synchronises and glitch-filters the asynchronous A/B encoder channels and decodes Gray-code transitions. It emits a one-cycle count-enable pulse plus a direction level, wired straight to the counter's EN and UP_DOWN inputs. It also flags illegal double transitions.

Parameters:
FILT, 4, consecutive cycles a synchronised channel must hold a new level before it is accepted (1..255)
MODE, 4, decode resolution: 4 = every edge, 2 = entries into 00/11, 1 = entries into 11 only
FW, $clog2(FILT+1), filter counter width (derived)

Ports:
CLK  input  1  system clock, rising edge
RSTn  input  1  asynchronous active-low reset
A_IN  input  1  encoder channel A, asynchronous to CLK
B_IN  input  1  encoder channel B, asynchronous to CLK
CLR  input  1  synchronous clear of ERR_STICKY
EN  output  1  one-cycle count pulse to counter EN
UP_DOWN  output  1  direction to counter UP_DOWN (1 = up)
ERR  output  1  one-cycle illegal-transition pulse
ERR_STICKY  output  1  latched error, cleared by CLR

Behaviour:
- Reset (async, RSTn=0): sync flops=0, filtered AB=00, filter counters=0, FSM=INIT, EN=0, UP_DOWN=1, ERR=0, ERR_STICKY=0.
- Synchroniser: 2 flops per channel.
- Filter, per channel:
  - Synced value equals filtered value: counter clears.
  - Synced value differs: counter increments.
  - Counter reaches FILT-1 while the value still differs: filtered value takes the synced value on that edge and the counter clears.
  - FILT=1 accepts on the first differing cycle.
- FSM INIT: waits until both channels' synced values have matched their last-sampled values for FILT cycles. It then loads filtered AB directly and moves to TRACK. No EN or ERR is produced in INIT, so the power-up encoder position never counts.
- FSM TRACK: compares previous and new filtered AB every cycle.
  - Forward sequence is 00→01→11→10→00 and sets UP_DOWN=1. The reverse sequence sets UP_DOWN=0.
  - A single-bit change that qualifies under MODE asserts EN for exactly one cycle. UP_DOWN updates on the same edge that EN rises.
  - A single-bit change that does not qualify under MODE: no EN, UP_DOWN unchanged.
  - Both bits changing in the same cycle: ERR=1 for one cycle, EN=0, UP_DOWN held, and the filtered state is accepted (resync).
  - No change: EN=0, ERR=0.
- UP_DOWN holds its last value between pulses, so the counter's TC direction stays valid.
- Latency: a level change first captured at edge k produces EN at edge k+FILT+2 (FILT+3 edges inclusive). With FILT=4 that is 7 edges.
- Back-to-back EN on consecutive cycles is legal; each transition produces at most one pulse.
- ERR_STICKY:
  - Set on any ERR.
  - CLR=1 clears it on the next edge.
  - ERR and CLR in the same cycle: sticky stays 1 (error wins).
- Reset mid-operation: all state returns to reset values immediately and the FSM re-enters INIT. No spurious EN after release.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_INIT, ST_TRACK)
  - Gray position constants (P00, P01, P11, P10)
  - MODE legal values
- One sub-module, quad_glitch_filter (synchroniser plus filter counter), instantiated once per channel.
- Decode, FSM and error logic stay in quad_decoder.

Test Plan:
- Forward x4, FILT=4: after INIT, drive AB 00→01→11→10→00 with each level held 10 cycles → 4 single-cycle EN pulses, UP_DOWN=1. Each EN appears 7 edges after its AB change. A downstream counter (M=32) goes 0→4.
- Reverse x4: AB 00→10→11→01→00 from counter value 0 → 4 EN pulses with UP_DOWN=0. Counter wraps 0→31→30→29→28 and TC asserts on the first pulse.
- Glitch reject, FILT=4: A pulses high for 3 cycles then returns → EN=0, ERR=0, filtered AB unchanged. The same pulse held 4 cycles → one EN.
- Illegal transition: AB 00→11 in one step → ERR one cycle, EN=0, ERR_STICKY=1. Assert CLR together with a second illegal step → sticky stays 1. CLR alone → sticky goes 0.
- Power-up and MODE=1: hold AB=11 through reset release → no EN/ERR. With MODE=1, one full forward cycle gives exactly 1 EN, on entry to 11.
- Mid-operation reset: assert RSTn low while an EN pulse is pending → EN=0, UP_DOWN=1 immediately. After release, the FSM re-enters INIT and produces no EN until a new qualifying transition.

Source files
------------

// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: FSM states, Gray-code
// positions, decode resolutions and small decode helpers.
package quad_decoder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Gray positions as {A, B}; forward rotation is P00 -> P01 -> P11 -> P10.
  localparam logic [1:0] P00 = 2'b00;
  localparam logic [1:0] P01 = 2'b01;
  localparam logic [1:0] P11 = 2'b11;
  localparam logic [1:0] P10 = 2'b10;

  // Legal MODE values (decode resolution).
  localparam int MODE_X4 = 4;
  localparam int MODE_X2 = 2;
  localparam int MODE_X1 = 1;

  // True when curr is the forward successor of prev.
  function automatic logic is_forward(input logic [1:0] prev, input logic [1:0] curr);
    case (prev)
      P00:     return curr == P01;
      P01:     return curr == P11;
      P11:     return curr == P10;
      default: return curr == P00;
    endcase
  endfunction

  // True when entering position curr produces a count at this resolution.
  function automatic logic qualifies(input int mode, input logic [1:0] curr);
    case (mode)
      MODE_X2: return (curr == P00) || (curr == P11);
      MODE_X1: return curr == P11;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a persistence
// filter that accepts a new level only after it has held FILT cycles.
module quad_glitch_filter #(
  parameter int FILT = 4,
  parameter int FW   = $clog2(FILT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  input  logic i_load,
  output logic o_sync,
  output logic o_filt
);

  localparam logic [FW-1:0] CNT_LAST = FW'(FILT - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_filt;
  logic [FW-1:0] r_cnt;

  // Synchronise the channel, then count how long the new level has persisted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes r_meta -> r_sync a real two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      if (i_load) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else if (r_sync == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + FW'(1);
      end
    end
  end

  assign o_sync = r_sync;
  assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: filters A/B, waits for a stable power-up
// position, then decodes Gray transitions into count-enable pulses, a held
// direction level and illegal-transition flags.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int FILT = 4,
  parameter int MODE = 4,
  parameter int FW   = $clog2(FILT + 1)
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic A_IN,
  input  logic B_IN,
  input  logic CLR,
  output logic EN,
  output logic UP_DOWN,
  output logic ERR,
  output logic ERR_STICKY
);

  localparam logic [FW-1:0] STABLE_LAST = FW'(FILT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    w_sync;
  logic [1:0]    w_filt;
  logic [1:0]    w_change;
  logic [1:0]    r_sync_last;
  logic [1:0]    r_ab_prev;
  logic [FW-1:0] r_stable;
  logic [FW-1:0] w_stable_next;
  logic          w_stable_match;
  logic          w_stable_done;
  logic          w_load;
  logic          w_en_next;
  logic          w_up_next;
  logic          w_err_next;
  logic          r_en;
  logic          r_up;
  logic          r_err;
  logic          r_sticky;

  quad_glitch_filter #(.FILT(FILT), .FW(FW)) u_filt_a (
    .clk     (CLK),
    .rst_n   (RSTn),
    .i_async (A_IN),
    .i_load  (w_load),
    .o_sync  (w_sync[1]),
    .o_filt  (w_filt[1])
  );

  quad_glitch_filter #(.FILT(FILT), .FW(FW)) u_filt_b (
    .clk     (CLK),
    .rst_n   (RSTn),
    .i_async (B_IN),
    .i_load  (w_load),
    .o_sync  (w_sync[0]),
    .o_filt  (w_filt[0])
  );

  assign w_change       = w_filt ^ r_ab_prev;
  assign w_stable_match = (w_sync == r_sync_last);
  assign w_stable_done  = w_stable_match && (r_stable == STABLE_LAST);

  // Power-up stability counter: runs only in INIT while the synced inputs hold still.
  always_comb begin
    w_stable_next = '0;
    if (r_state == ST_INIT && w_stable_match && !w_stable_done) begin
      w_stable_next = r_stable + FW'(1);
    end
  end

  // Next-state and decode: INIT seeds the position, TRACK classifies each change.
  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_en_next    = 1'b0;
    w_err_next   = 1'b0;
    w_up_next    = r_up;
    case (r_state)
      ST_INIT: begin
        if (w_stable_done) begin
          w_load       = 1'b1;
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_change == 2'b11) begin
          w_err_next = 1'b1;
        end else if (w_change != 2'b00 && qualifies(MODE, w_filt)) begin
          w_en_next = 1'b1;
          w_up_next = is_forward(r_ab_prev, w_filt);
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Position history, registered outputs and the sticky error (error beats clear).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync_last <= P00;
      r_stable    <= '0;
      r_ab_prev   <= P00;
      r_en        <= 1'b0;
      r_up        <= 1'b1;
      r_err       <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_sync_last <= w_sync;
      r_stable    <= w_stable_next;
      r_ab_prev   <= w_load ? w_sync : w_filt;
      r_en        <= w_en_next;
      r_up        <= w_up_next;
      r_err       <= w_err_next;
      if (w_err_next || r_err) begin
        r_sticky <= 1'b1;
      end else if (CLR) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign EN         = r_en;
  assign UP_DOWN    = r_up;
  assign ERR        = r_err;
  assign ERR_STICKY = r_sticky;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: three instances (MODE 4, 2, 1) share the encoder
// inputs; a reference model queues expected pulses per instance and a
// negedge monitor pops and compares them as the DUTs pulse.
module tb_quad_decoder;

  localparam int FILT = 4;
  localparam int NI   = 3;

  typedef struct {
    bit is_err;
    bit up;
    int cyc;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  logic A_IN = 1'b0;
  logic B_IN = 1'b0;
  logic CLR  = 1'b0;
  logic [NI-1:0] en_v;
  logic [NI-1:0] up_v;
  logic [NI-1:0] err_v;
  logic [NI-1:0] sticky_v;

  int         cyc   = 0;
  int         n_vec = 0;
  int         n_mis = 0;
  logic [1:0] pos;
  bit         mup [NI];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int M = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    quad_decoder #(.FILT(FILT), .MODE(M)) u_dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .A_IN       (A_IN),
      .B_IN       (B_IN),
      .CLR        (CLR),
      .EN         (en_v[g]),
      .UP_DOWN    (up_v[g]),
      .ERR        (err_v[g]),
      .ERR_STICKY (sticky_v[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int mode_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
  endfunction

  // Position index along the forward rotation 00,01,11,10.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic bit qual(input int mode, input logic [1:0] v);
    if (mode == 4) return 1'b1;
    if (mode == 2) return (v == 2'b00) || (v == 2'b11);
    return v == 2'b11;
  endfunction

  function automatic int q_size(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int q_front_cyc(input int g);
    case (g)
      0:       return q0[0].cyc;
      1:       return q1[0].cyc;
      default: return q2[0].cyc;
    endcase
  endfunction

  task automatic q_push(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int g, output exp_t e);
    case (g)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer for one instance.
  task automatic monitor_one(input int g);
    exp_t e;
    while (q_size(g) != 0 && q_front_cyc(g) < cyc) begin
      q_pop(g, e);
      n_vec++;
      n_mis++;
      $display("FAIL missed_pulse dut%0d: nothing seen, required %s at cycle %0d",
               g, e.is_err ? "ERR" : "EN", e.cyc);
    end
    if (en_v[g] || err_v[g]) begin
      if (q_size(g) == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL spurious_pulse dut%0d: en=%0b err=%0b at cycle %0d, required none",
                 g, en_v[g], err_v[g], cyc);
      end else begin
        q_pop(g, e);
        check($sformatf("pulse_kind_dut%0d", g), {30'd0, en_v[g], err_v[g]}, e.is_err ? 1 : 2);
        check($sformatf("pulse_cycle_dut%0d", g), cyc, e.cyc);
        check($sformatf("up_down_dut%0d", g), up_v[g], e.up);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RSTn === 1'b1) begin
      for (int g = 0; g < NI; g++) monitor_one(g);
    end
  end

  // Drive a new AB level and queue what each resolution should report.
  task automatic issue(input logic [1:0] nab);
    int   c;
    exp_t e;
    @(posedge CLK);
    #1;
    {A_IN, B_IN} = nab;
    c = cyc;
    if (nab != pos) begin
      for (int g = 0; g < NI; g++) begin
        e.cyc = c + FILT + 3;
        if ((nab ^ pos) == 2'b11) begin
          e.is_err = 1'b1;
          e.up     = mup[g];
          q_push(g, e);
        end else if (qual(mode_of(g), nab)) begin
          e.is_err = 1'b0;
          e.up     = (gidx(nab) == (gidx(pos) + 1) % 4);
          mup[g]   = e.up;
          q_push(g, e);
        end
      end
    end
    pos = nab;
  endtask

  task automatic apply_step(input logic [1:0] nab, input int hold);
    issue(nab);
    repeat (hold - 1) @(posedge CLK);
  endtask

  // Short excursion that must be rejected by the filters.
  task automatic apply_glitch(input logic [1:0] gab, input int len);
    logic [1:0] home;
    home = pos;
    @(posedge CLK);
    #1;
    {A_IN, B_IN} = gab;
    repeat (len - 1) @(posedge CLK);
    @(posedge CLK);
    #1;
    {A_IN, B_IN} = home;
    repeat (FILT + 2) @(posedge CLK);
  endtask

  initial begin
    int         r;
    int         h;
    int         l;
    logic [1:0] v;

    pos = 2'b11;
    for (int g = 0; g < NI; g++) mup[g] = 1'b1;
    {A_IN, B_IN} = 2'b11;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset_en_dut%0d", g), en_v[g], 0);
      check($sformatf("reset_up_dut%0d", g), up_v[g], 1);
      check($sformatf("reset_err_dut%0d", g), err_v[g], 0);
      check($sformatf("reset_sticky_dut%0d", g), sticky_v[g], 0);
    end
    @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (20) @(posedge CLK);

    // Move to 00, then one full forward and one full reverse rotation.
    apply_step(2'b10, 12);
    apply_step(2'b00, 12);
    apply_step(2'b01, 10);
    apply_step(2'b11, 10);
    apply_step(2'b10, 10);
    apply_step(2'b00, 10);
    apply_step(2'b10, 10);
    apply_step(2'b11, 10);
    apply_step(2'b01, 10);
    apply_step(2'b00, 10);

    // Glitch one cycle short of FILT, then exactly FILT.
    apply_glitch(2'b10, FILT - 1);
    apply_step(2'b10, FILT);
    apply_step(2'b00, 12);

    // B then A one cycle apart: back-to-back pulses.
    apply_step(2'b01, 1);
    apply_step(2'b11, 12);

    // Illegal double transition 00 -> 11.
    apply_step(2'b10, 12);
    apply_step(2'b00, 12);
    apply_step(2'b11, 12);
    @(negedge CLK);
    for (int g = 0; g < NI; g++) check($sformatf("sticky_set_dut%0d", g), sticky_v[g], 1);

    // Second illegal step with CLR held through the ERR cycle: error wins.
    @(posedge CLK);
    #1 CLR = 1'b1;
    issue(2'b00);
    for (int i = 0; i < FILT + 10 && !err_v[0]; i++) @(negedge CLK);
    check("err_seen_with_clr", err_v[0], 1);
    @(posedge CLK);
    #1 CLR = 1'b0;
    @(negedge CLK);
    for (int g = 0; g < NI; g++) check($sformatf("sticky_err_wins_dut%0d", g), sticky_v[g], 1);
    @(posedge CLK);
    #1 CLR = 1'b1;
    @(posedge CLK);
    #1 CLR = 1'b0;
    @(negedge CLK);
    for (int g = 0; g < NI; g++) check($sformatf("sticky_clear_dut%0d", g), sticky_v[g], 0);
    repeat (4) @(posedge CLK);

    // Randomised steps and glitches.
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        v = pos ^ 2'($urandom_range(1, 3));
        l = $urandom_range(1, FILT - 1);
        apply_glitch(v, l);
      end else begin
        v = 2'($urandom_range(0, 3));
        h = $urandom_range(FILT, FILT + 6);
        apply_step(v, h);
      end
    end
    repeat (FILT + 6) @(posedge CLK);

    // Reverse step (UP_DOWN low), then reset while a forward pulse is pending.
    apply_step(gval(gidx(pos) + 3), FILT + 8);
    issue(gval(gidx(pos) + 1));
    repeat (FILT + 1) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("midreset_en_dut%0d", g), en_v[g], 0);
      check($sformatf("midreset_up_dut%0d", g), up_v[g], 1);
      check($sformatf("midreset_err_dut%0d", g), err_v[g], 0);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    for (int g = 0; g < NI; g++) mup[g] = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (25) @(posedge CLK);
    apply_step(gval(gidx(pos) + 1), 15);
    apply_step(gval(gidx(pos) + 1), 15);

    repeat (FILT + 8) @(posedge CLK);
    @(negedge CLK);
    for (int g = 0; g < NI; g++) check($sformatf("drain_dut%0d", g), q_size(g), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
